pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage pipeline. It generates EX-stage and decode-stage (branch-compare) forwarding selects and load-use and branch-in-decode stalls with EX flush, and it adds two things the earlier unit lacked: a stall on a busy multi-cycle multiply/divide unit with configurable latency, and a saturating stall-cycle performance counter. It sits beside the decode stage and drives the F/D pipeline-register enables, the D/E flush, and the forwarding muxes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width; register 0 is hardwired zero.
- MC_LAT, 4, multi-cycle unit latency in cycles; must be ≥1.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- rs_d, rt_d  in  REG_ADDR_W  decode-stage source registers.
- rs_e, rt_e  in  REG_ADDR_W  execute-stage source registers.
- write_reg_e, write_reg_m, write_reg_w  in  REG_ADDR_W  destination registers in EX, MEM and WB.
- reg_write_e, reg_write_m, reg_write_w  in  1  register write enables per stage.
- mem_to_reg_e, mem_to_reg_m  in  1  the instruction in that stage is a load.
- branch_d  in  1  the decode instruction is a branch resolved in decode.
- mc_start_e  in  1  the EX instruction issues to the multi-cycle unit.
- mc_use_d  in  1  the decode instruction either reads the multi-cycle result (HI/LO move) or issues a new multi-cycle op.
- cnt_clr  in  1  synchronous clear of stall_count.
- stall_f, stall_d, flush_e  out  1  pipeline control.
- forward_ae, forward_be  out  2  EX operand select: 00 register file, 01 WB, 10 MEM.
- forward_ad, forward_bd  out  1  decode compare operand taken from MEM.
- stall_cause  out  2  0 none, 1 load-use, 2 branch, 3 multi-cycle.
- mc_busy  out  1  multi-cycle unit busy.
- stall_count  out  CNT_W  count of stalled cycles.

## Operation
- **Forwarding (combinational).**
  - forward_ae = 10 if rs_e≠0 && reg_write_m && write_reg_m==rs_e.
  - Otherwise forward_ae = 01 if rs_e≠0 && reg_write_w && write_reg_w==rs_e.
  - Otherwise forward_ae = 00.
  - MEM has priority over WB. forward_be is the same using rt_e.
  - forward_ad = rs_d≠0 && reg_write_m && write_reg_m==rs_d. forward_bd is the same using rt_d.
- **Load-use stall (lw_stall).** mem_to_reg_e && write_reg_e≠0 && (write_reg_e==rs_d || write_reg_e==rt_d).
- **Branch stall (br_stall).** branch_d && the matching source is nonzero && one of:
  - reg_write_e && write_reg_e matches rs_d or rt_d;
  - mem_to_reg_m && write_reg_m matches rs_d or rt_d.
- **Multi-cycle stall (mc_stall).** mc_busy && mc_use_d.
- **Stall outputs.** stall_f = stall_d = flush_e = lw_stall | br_stall | mc_stall.
- **stall_cause priority.** multi-cycle (3) over load-use (1) over branch (2); 0 when there is no stall.
- **Multi-cycle tracker.** Down-counter mc_cnt, width clog2(MC_LAT+1).
  - States: IDLE (mc_cnt==0) and BUSY (mc_cnt≠0). mc_busy = (mc_cnt≠0).
  - IDLE→BUSY: mc_start_e loads MC_LAT.
  - In BUSY, mc_cnt decrements each cycle; BUSY→IDLE when it reaches 0.
  - mc_start_e while BUSY is ignored, and the count is not restarted. Decode stalling prevents this case legally; the bench asserts it never occurs.
- **Stall counter.**
  - Increments on every clk edge where stall_d=1.
  - Saturates at 2^CNT_W−1.
  - cnt_clr wins over an increment in the same cycle (result 0).

## Timing
- Forwarding, stall, flush and stall_cause are same-cycle combinational; no extra latency.
- mc_start_e sampled high at edge t → mc_busy is high for cycles t+1 … t+MC_LAT and low at t+MC_LAT+1.
  - A mc_use_d in the last busy cycle still stalls.
  - The first cycle after busy proceeds.
- With MC_LAT=1, exactly one busy cycle.
- stall_count reflects a stall one edge later.
- **Reset (asynchronous).**
  - mc_cnt=0 and stall_count=0 immediately, so mc_busy=0 and mc_stall=0.
  - Combinational outputs follow their inputs during reset.
  - Reset during BUSY aborts tracking immediately.
- Simultaneous hazards: the stall outputs are the OR of all causes; stall_cause follows the priority above.

## Structure
- **Package pipeline_hazard_pkg:**
  - forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - stall-cause constants CAUSE_NONE, CAUSE_LOAD, CAUSE_BRANCH, CAUSE_MC.
- **Sub-module mc_busy_tracker.**
  - Parameter MC_LAT.
  - Ports clk, rst, mc_start_e, mc_busy.
  - Holds the down-counter FSM.
- Forwarding, stall logic and the stall counter stay in the top module.

## Test plan
- **Forwarding priority.** rs_e=5, write_reg_m=5, write_reg_w=5, both write enables high → forward_ae=10. Drop reg_write_m → 01. Set rs_e=0 → 00.
- **Load-use.** mem_to_reg_e=1, write_reg_e=8, rt_d=8 → stall_f=stall_d=flush_e=1, stall_cause=1. The next cycle, with the load in MEM, → no stall.
- **Branch.** branch_d=1, rs_d=3, reg_write_e=1, write_reg_e=3 → stall, cause 2. The same case with register 0 → no stall.
- **Multi-cycle, MC_LAT=4.** mc_start_e pulse at edge t → mc_busy high for exactly 4 cycles. mc_use_d held high → stall in those 4 cycles only, cause 3.
- **Counter.** CNT_W=3, stall_d held 10 cycles → stall_count saturates at 7. cnt_clr together with stall_d → 0.
- **Reset mid-busy.** Assert rst 2 cycles after mc_start_e → mc_busy and stall_count go to 0 immediately, with no stall on mc_use_d.

Source files
------------

// File: rtl/pipeline_hazard_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipeline_hazard_pkg;

    // EX-stage forwarding mux selects.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Stall cause reported alongside the stall outputs.
    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_LOAD   = 2'd1;
    localparam logic [1:0] CAUSE_BRANCH = 2'd2;
    localparam logic [1:0] CAUSE_MC     = 2'd3;

    // Multi-cycle tracker state, derived from its down-counter.
    typedef enum logic {
        StIdle,
        StBusy
    } mc_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_mc_busy_tracker.sv
// Tracks occupancy of the multi-cycle multiply/divide unit with a down-counter.
module mc_busy_tracker
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic mc_start_e,
    output logic mc_busy
);

    localparam int unsigned CntW = $clog2(MC_LAT + 1);
    localparam logic [CntW-1:0] LatVal = CntW'(MC_LAT);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] mc_cnt_q;
    logic [CntW-1:0] mc_cnt_d;
    mc_state_e       state;

    // The state is fully encoded by the counter: zero means idle.
    assign state = (mc_cnt_q != '0) ? StBusy : StIdle;

    // Next count: load latency on issue while idle, count down while busy.
    // An issue seen while busy is ignored; decode stalling keeps it from happening.
    always_comb begin
        mc_cnt_d = mc_cnt_q;
        unique case (state)
            StIdle: begin
                if (mc_start_e) begin
                    mc_cnt_d = LatVal;
                end
            end
            StBusy: begin
                mc_cnt_d = mc_cnt_q - CntOne;
            end
            default: begin
                mc_cnt_d = '0;
            end
        endcase
    end

    // Counter register; reset aborts any in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_cnt_q <= '0;
        end else begin
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign mc_busy = (state == StBusy);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use,
// branch-in-decode and multi-cycle stalls, and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipeline_hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned MC_LAT     = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs_d,
    input  logic [REG_ADDR_W-1:0] rt_d,
    input  logic [REG_ADDR_W-1:0] rs_e,
    input  logic [REG_ADDR_W-1:0] rt_e,
    input  logic [REG_ADDR_W-1:0] write_reg_e,
    input  logic [REG_ADDR_W-1:0] write_reg_m,
    input  logic [REG_ADDR_W-1:0] write_reg_w,
    input  logic                  reg_write_e,
    input  logic                  reg_write_m,
    input  logic                  reg_write_w,
    input  logic                  mem_to_reg_e,
    input  logic                  mem_to_reg_m,
    input  logic                  branch_d,
    input  logic                  mc_start_e,
    input  logic                  mc_use_d,
    input  logic                  cnt_clr,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_e,
    output logic [1:0]            forward_ae,
    output logic [1:0]            forward_be,
    output logic                  forward_ad,
    output logic                  forward_bd,
    output logic [1:0]            stall_cause,
    output logic                  mc_busy,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic lw_stall;
    logic br_stall;
    logic mc_stall;
    logic stall;

    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    mc_busy_tracker #(
        .MC_LAT (MC_LAT)
    ) u_mc_busy_tracker (
        .clk        (clk),
        .rst        (rst),
        .mc_start_e (mc_start_e),
        .mc_busy    (mc_busy)
    );

    // EX operand forwarding; MEM is younger than WB so it takes priority.
    always_comb begin
        forward_ae = FWD_RF;
        if (rs_e != '0 && reg_write_m && write_reg_m == rs_e) begin
            forward_ae = FWD_MEM;
        end else if (rs_e != '0 && reg_write_w && write_reg_w == rs_e) begin
            forward_ae = FWD_WB;
        end
        forward_be = FWD_RF;
        if (rt_e != '0 && reg_write_m && write_reg_m == rt_e) begin
            forward_be = FWD_MEM;
        end else if (rt_e != '0 && reg_write_w && write_reg_w == rt_e) begin
            forward_be = FWD_WB;
        end
    end

    // Decode-stage branch comparator can only bypass from MEM.
    assign forward_ad = (rs_d != '0) && reg_write_m && (write_reg_m == rs_d);
    assign forward_bd = (rt_d != '0) && reg_write_m && (write_reg_m == rt_d);

    // Hazard detection. A branch needs its operands in decode, so it must wait
    // for an ALU result still in EX or a load result still in MEM.
    always_comb begin
        lw_stall = mem_to_reg_e && (write_reg_e != '0) &&
                   ((write_reg_e == rs_d) || (write_reg_e == rt_d));
        br_stall = branch_d &&
                   (((rs_d != '0) &&
                     ((reg_write_e && write_reg_e == rs_d) ||
                      (mem_to_reg_m && write_reg_m == rs_d))) ||
                    ((rt_d != '0) &&
                     ((reg_write_e && write_reg_e == rt_d) ||
                      (mem_to_reg_m && write_reg_m == rt_d))));
        mc_stall = mc_busy && mc_use_d;
        stall    = lw_stall | br_stall | mc_stall;
    end

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    // Report a single cause: multi-cycle over load-use over branch.
    always_comb begin
        stall_cause = CAUSE_NONE;
        if (mc_stall) begin
            stall_cause = CAUSE_MC;
        end else if (lw_stall) begin
            stall_cause = CAUSE_LOAD;
        end else if (br_stall) begin
            stall_cause = CAUSE_BRANCH;
        end
    end

    // Stall counter next value: clear wins, otherwise saturating increment.
    always_comb begin
        stall_count_d = stall_count_q;
        if (cnt_clr) begin
            stall_count_d = '0;
        end else if (stall && stall_count_q != CntMax) begin
            stall_count_d = stall_count_q + CntOne;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (MC_LAT=4, CNT_W=3).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] write_reg_e, write_reg_m, write_reg_w;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic       mem_to_reg_e, mem_to_reg_m;
    logic       branch_d, mc_start_e, mc_use_d, cnt_clr;
    logic       stall_f, stall_d, flush_e;
    logic [1:0] forward_ae, forward_be;
    logic       forward_ad, forward_bd;
    logic [1:0] stall_cause;
    logic       mc_busy;
    logic [2:0] stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_hazard_ctrl #(
        .REG_ADDR_W (5),
        .MC_LAT     (4),
        .CNT_W      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .rs_e         (rs_e),
        .rt_e         (rt_e),
        .write_reg_e  (write_reg_e),
        .write_reg_m  (write_reg_m),
        .write_reg_w  (write_reg_w),
        .reg_write_e  (reg_write_e),
        .reg_write_m  (reg_write_m),
        .reg_write_w  (reg_write_w),
        .mem_to_reg_e (mem_to_reg_e),
        .mem_to_reg_m (mem_to_reg_m),
        .branch_d     (branch_d),
        .mc_start_e   (mc_start_e),
        .mc_use_d     (mc_use_d),
        .cnt_clr      (cnt_clr),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_e      (flush_e),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .forward_ad   (forward_ad),
        .forward_bd   (forward_bd),
        .stall_cause  (stall_cause),
        .mc_busy      (mc_busy),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
        write_reg_e = '0; write_reg_m = '0; write_reg_w = '0;
        reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        mem_to_reg_e = 1'b0; mem_to_reg_m = 1'b0;
        branch_d = 1'b0; mc_start_e = 1'b0; mc_use_d = 1'b0;
    endtask

    task automatic check_stall(input string tag, input logic exp_stall, input logic [1:0] exp_cause);
        check({tag, "_stall_f"}, stall_f, exp_stall);
        check({tag, "_stall_d"}, stall_d, exp_stall);
        check({tag, "_flush_e"}, flush_e, exp_stall);
        check({tag, "_cause"}, stall_cause, exp_cause);
    endtask

    // Issuing to the multi-cycle unit while it is busy must never happen.
    always @(posedge clk) begin
        if (!rst && mc_start_e) check("mc_start_while_busy", mc_busy, 1'b0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        cnt_clr = 1'b0;
        rst     = 1'b1;
        // Combinational paths follow inputs while reset is held.
        rs_e = 5'd5; write_reg_m = 5'd5; reg_write_m = 1'b1;
        #2;
        check("rst_mc_busy", mc_busy, 1'b0);
        check("rst_count", stall_count, 3'd0);
        check("rst_fwd_ae", forward_ae, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        cnt_clr = 1'b1;

        // Forwarding priority: MEM over WB, register 0 never forwarded.
        @(negedge clk);
        clear_inputs();
        rs_e = 5'd5; write_reg_m = 5'd5; write_reg_w = 5'd5;
        reg_write_m = 1'b1; reg_write_w = 1'b1;
        #1;
        check("fwd_ae_mem", forward_ae, 2'b10);
        check("fwd_be_rf", forward_be, 2'b00);
        reg_write_m = 1'b0;
        #1;
        check("fwd_ae_wb", forward_ae, 2'b01);
        rs_e = 5'd0; write_reg_w = 5'd0;
        #1;
        check("fwd_ae_zero", forward_ae, 2'b00);
        rt_e = 5'd7; write_reg_m = 5'd7; reg_write_m = 1'b1; write_reg_w = 5'd7;
        #1;
        check("fwd_be_mem", forward_be, 2'b10);
        rs_d = 5'd7; rt_d = 5'd6;
        #1;
        check("fwd_ad", forward_ad, 1'b1);
        check("fwd_bd_nomatch", forward_bd, 1'b0);
        check_stall("fwd_nostall", 1'b0, 2'd0);

        // Load-use: stall now, counted one edge later, gone once load is in MEM.
        @(negedge clk);
        clear_inputs();
        cnt_clr = 1'b0;
        mem_to_reg_e = 1'b1; reg_write_e = 1'b1; write_reg_e = 5'd8; rt_d = 5'd8;
        #1;
        check_stall("lw", 1'b1, 2'd1);
        @(posedge clk); #1;
        check("lw_count", stall_count, 3'd1);
        @(negedge clk);
        mem_to_reg_e = 1'b0; reg_write_e = 1'b0; write_reg_e = 5'd0;
        mem_to_reg_m = 1'b1; reg_write_m = 1'b1; write_reg_m = 5'd8;
        #1;
        check_stall("lw_next", 1'b0, 2'd0);
        check("lw_next_fwd_bd", forward_bd, 1'b1);
        @(posedge clk); #1;
        check("lw_next_count", stall_count, 3'd1);
        @(negedge clk);
        clear_inputs();
        cnt_clr = 1'b1;
        mem_to_reg_e = 1'b1; write_reg_e = 5'd0;
        #1;
        check_stall("lw_r0", 1'b0, 2'd0);

        // Branch in decode.
        @(negedge clk);
        clear_inputs();
        branch_d = 1'b1; rs_d = 5'd3; reg_write_e = 1'b1; write_reg_e = 5'd3;
        #1;
        check_stall("br_ex", 1'b1, 2'd2);
        rs_d = 5'd0; write_reg_e = 5'd0;
        #1;
        check_stall("br_r0", 1'b0, 2'd0);
        reg_write_e = 1'b0;
        rt_d = 5'd4; mem_to_reg_m = 1'b1; write_reg_m = 5'd4;
        #1;
        check_stall("br_mem_load", 1'b1, 2'd2);
        mem_to_reg_m = 1'b0;
        #1;
        check_stall("br_mem_alu", 1'b0, 2'd0);
        // Load-use and branch together: load-use cause wins.
        mem_to_reg_e = 1'b1; write_reg_e = 5'd4; reg_write_e = 1'b1;
        #1;
        check_stall("br_lw_both", 1'b1, 2'd1);

        // Multi-cycle: busy for exactly 4 cycles after the issue edge.
        @(negedge clk);
        clear_inputs();
        mc_start_e = 1'b1; mc_use_d = 1'b1;
        #1;
        check_stall("mc_issue", 1'b0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mc_start_e = 1'b0;
            mem_to_reg_e = (i == 2); write_reg_e = (i == 2) ? 5'd8 : 5'd0;
            rt_d = (i == 2) ? 5'd8 : 5'd0;
            #1;
            check($sformatf("mc_busy_%0d", i), mc_busy, (i < 4));
            check_stall($sformatf("mc_%0d", i), (i < 4), (i < 4) ? 2'd3 : 2'd0);
        end

        // Counter saturation at 7 with CNT_W=3, then clear beats increment.
        @(negedge clk);
        clear_inputs();
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        mem_to_reg_e = 1'b1; write_reg_e = 5'd9; rs_d = 5'd9;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("cnt_%0d", i), stall_count, (i < 7) ? i + 1 : 7);
        end
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        check("cnt_clr_wins", stall_count, 3'd0);
        @(negedge clk);
        cnt_clr = 1'b0;
        @(posedge clk); #1;
        check("cnt_after_clr", stall_count, 3'd1);

        // Reset two cycles into a busy period aborts tracking at once.
        @(negedge clk);
        clear_inputs();
        cnt_clr = 1'b1; mc_start_e = 1'b1; mc_use_d = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0; mc_start_e = 1'b0;
        #1;
        check("rb_busy", mc_busy, 1'b1);
        check("rb_count0", stall_count, 3'd0);
        @(negedge clk);
        #1;
        check("rb_count1", stall_count, 3'd1);
        check_stall("rb_mc", 1'b1, 2'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rb_rst_busy", mc_busy, 1'b0);
        check("rb_rst_count", stall_count, 3'd0);
        check_stall("rb_rst", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rb_after_busy", mc_busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
